// File: rtl/surf_cout_align.sv
// SURF COUT/DOUT lane aligner: sweeps IDELAY taps per lane, centres the
// widest stable eye, then bitslips the ISERDES until the training word lands.
module surf_cout_align #(
    parameter logic [3:0] COUT_TRAIN    = 4'h8,
    parameter logic [7:0] DOUT_TRAIN    = 8'hA8,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CHECK_CYCLES  = 64,
    parameter int         MIN_EYE       = 4
) (
    input  logic       sysclk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [3:0] cout_i,
    input  logic [7:0] dout_i,
    output logic [4:0] idelay_value_o,
    output logic       idelay_cout_load_o,
    output logic       idelay_dout_load_o,
    output logic       iserdes_rst_o,
    output logic       iserdes_cout_bitslip_o,
    output logic       iserdes_dout_bitslip_o,
    output logic       busy_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [4:0] cout_delay_o,
    output logic [4:0] dout_delay_o
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SRST, ST_LOAD, ST_SETTLE, ST_CHECK, ST_NEXT,
        ST_PICK, ST_SLIP, ST_SLIPWAIT, ST_LOCKED, ST_FAIL
    } state_t;

    localparam logic [7:0] SRST_LAST   = 8'd3;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] CHECK_LAST  = 8'(CHECK_CYCLES - 1);
    localparam logic [7:0] SW_LAST     = 8'(SETTLE_CYCLES + 4);

    state_t     state_q, state_d;
    logic       lane_q;
    logic [4:0] tap_q;
    logic [7:0] cnt_q;
    logic [7:0] first_q;
    logic       good_q;
    logic [4:0] run_start_q, best_start_q;
    logic [5:0] run_len_q, best_len_q;
    logic [3:0] slip_q;
    logic [4:0] value_q;
    logic [4:0] cout_dly_q, dout_dly_q;

    logic [7:0] word, train;
    logic [3:0] width;
    logic [4:0] center;
    logic       eye_ok, match, start_acc, lane_sw;
    logic [5:0] run_len_inc;
    logic [4:0] run_start_cur;

    // True when the sample equals any bit-rotation of the lane's training word
    function automatic logic rot_ok(input logic [7:0] w, input logic ln);
        logic       hit;
        logic [7:0] r8;
        logic [3:0] r4;
        hit = 1'b0;
        r8  = DOUT_TRAIN;
        r4  = COUT_TRAIN;
        for (int i = 0; i < 8; i++) begin
            if (ln) hit = hit | (w == r8);
            else    hit = hit | (w == {4'h0, r4});
            r8 = {r8[6:0], r8[7]};
            r4 = {r4[2:0], r4[3]};
        end
        return hit;
    endfunction

    assign word          = lane_q ? dout_i : {4'h0, cout_i};
    assign train         = lane_q ? DOUT_TRAIN : {4'h0, COUT_TRAIN};
    assign width         = lane_q ? 4'd8 : 4'd4;
    assign center        = 5'(6'(best_start_q) + (best_len_q >> 1));
    assign eye_ok        = best_len_q >= 6'(MIN_EYE);
    assign match         = word == train;
    assign run_len_inc   = run_len_q + 6'd1;
    assign run_start_cur = (run_len_q == 6'd0) ? tap_q : run_start_q;
    assign start_acc     = start_i && (state_q == ST_IDLE ||
                           state_q == ST_LOCKED || state_q == ST_FAIL);
    assign lane_sw       = state_q == ST_SLIPWAIT && cnt_q == SW_LAST &&
                           match && !lane_q;
    assign cout_delay_o  = cout_dly_q;
    assign dout_delay_o  = dout_dly_q;

    // State register
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_d                = state_q;
        idelay_value_o         = value_q;
        idelay_cout_load_o     = 1'b0;
        idelay_dout_load_o     = 1'b0;
        iserdes_rst_o          = 1'b0;
        iserdes_cout_bitslip_o = 1'b0;
        iserdes_dout_bitslip_o = 1'b0;
        busy_o                 = 1'b1;
        locked_o               = 1'b0;
        fail_o                 = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                busy_o   = 1'b0;
                locked_o = state_q == ST_LOCKED;
                fail_o   = state_q == ST_FAIL;
                if (start_i) state_d = ST_SRST;
            end
            ST_SRST: begin
                iserdes_rst_o = 1'b1;
                if (cnt_q == SRST_LAST) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                idelay_value_o     = tap_q;
                idelay_cout_load_o = !lane_q;
                idelay_dout_load_o = lane_q;
                state_d            = ST_SETTLE;
            end
            ST_SETTLE: if (cnt_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK:  if (cnt_q == CHECK_LAST)  state_d = ST_NEXT;
            ST_NEXT:   state_d = (tap_q == 5'd31) ? ST_PICK : ST_LOAD;
            ST_PICK: begin
                if (eye_ok) begin
                    idelay_value_o     = center;
                    idelay_cout_load_o = !lane_q;
                    idelay_dout_load_o = lane_q;
                    state_d            = ST_SLIPWAIT;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_SLIPWAIT: begin
                if (cnt_q == SW_LAST) begin
                    if (match)                state_d = lane_q ? ST_LOCKED : ST_LOAD;
                    else if (slip_q == width) state_d = ST_FAIL;
                    else                      state_d = ST_SLIP;
                end
            end
            ST_SLIP: begin
                iserdes_cout_bitslip_o = !lane_q;
                iserdes_dout_bitslip_o = lane_q;
                state_d                = ST_SLIPWAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sweep datapath: counters, tap, eye tracking and chosen delays
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            lane_q       <= 1'b0;
            tap_q        <= '0;
            first_q      <= '0;
            good_q       <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            slip_q       <= '0;
            value_q      <= '0;
            cout_dly_q   <= '0;
            dout_dly_q   <= '0;
        end else begin
            cnt_q <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
            if (start_acc || lane_sw) begin
                lane_q       <= lane_sw;
                tap_q        <= '0;
                run_start_q  <= '0;
                run_len_q    <= '0;
                best_start_q <= '0;
                best_len_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_LOAD: value_q <= tap_q;
                    ST_CHECK: begin
                        if (cnt_q == 8'd0) begin
                            first_q <= word;
                            good_q  <= rot_ok(word, lane_q);
                        end else begin
                            good_q  <= good_q && (word == first_q);
                        end
                    end
                    ST_NEXT: begin
                        if (good_q) begin
                            run_len_q   <= run_len_inc;
                            run_start_q <= run_start_cur;
                            if (run_len_inc > best_len_q) begin
                                best_len_q   <= run_len_inc;
                                best_start_q <= run_start_cur;
                            end
                        end else begin
                            run_len_q <= '0;
                        end
                        if (tap_q != 5'd31) tap_q <= tap_q + 5'd1;
                    end
                    ST_PICK: begin
                        slip_q <= '0;
                        if (eye_ok) begin
                            value_q <= center;
                            if (lane_q) dout_dly_q <= center;
                            else        cout_dly_q <= center;
                        end
                    end
                    ST_SLIP: slip_q <= slip_q + 4'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_surf_cout_align.sv
// Randomised bench for surf_cout_align: a channel model serves lane words
// per loaded tap and slip count; results are checked against an eye model.
module tb_surf_cout_align;

    localparam logic [3:0] CT = 4'h8;
    localparam logic [7:0] DT = 8'hA8;

    logic       sysclk, rst_n, start;
    logic [3:0] cout;
    logic [7:0] dout;
    logic [4:0] val, cdly, ddly;
    logic       ld_c, ld_d, irst, bs_c, bs_d, busy, locked, fail;

    int n_chk = 0, n_fail = 0;

    logic [31:0] mask_c, mask_d;
    int          base_c, base_d;
    int          tap_c, tap_d, sl_c, sl_d;
    int          n_ld_c, n_ld_d, n_bs_c, n_bs_d, n_excl;

    surf_cout_align dut (
        .sysclk_i              (sysclk),
        .rst_n_i               (rst_n),
        .start_i               (start),
        .cout_i                (cout),
        .dout_i                (dout),
        .idelay_value_o        (val),
        .idelay_cout_load_o    (ld_c),
        .idelay_dout_load_o    (ld_d),
        .iserdes_rst_o         (irst),
        .iserdes_cout_bitslip_o(bs_c),
        .iserdes_dout_bitslip_o(bs_d),
        .busy_o                (busy),
        .locked_o              (locked),
        .fail_o                (fail),
        .cout_delay_o          (cdly),
        .dout_delay_o          (ddly)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rot4(input logic [3:0] v, input int n);
        logic [3:0] r = v;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi && t < 32; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Longest run of good taps, earliest on ties
    function automatic void best_eye(input logic [31:0] m,
                                     output int st, output int ln);
        int cs = 0, cl = 0;
        st = 0; ln = 0;
        for (int t = 0; t < 32; t++) begin
            if (m[t]) begin
                if (cl == 0) cs = t;
                cl++;
                if (cl > ln) begin ln = cl; st = cs; end
            end else cl = 0;
        end
    endfunction

    function automatic int outs();
        return int'({ld_c, ld_d, irst, bs_c, bs_d, busy, locked, fail,
                     val, cdly, ddly});
    endfunction

    // Channel model: tracks loaded taps and slips, serves words on negedge
    initial begin
        cout = '0; dout = '0;
        tap_c = 0; tap_d = 0; sl_c = 0; sl_d = 0;
        forever begin
            @(negedge sysclk);
            if (rst_n) begin
                if (int'(ld_c) + int'(ld_d) + int'(irst) +
                    int'(bs_c) + int'(bs_d) > 1) n_excl++;
                if (irst) begin sl_c = 0; sl_d = 0; end
                if (ld_c) begin tap_c = int'(val); n_ld_c++; end
                if (ld_d) begin tap_d = int'(val); n_ld_d++; end
                if (bs_c) begin sl_c++; n_bs_c++; end
                if (bs_d) begin sl_d++; n_bs_d++; end
            end
            cout = mask_c[tap_c] ? rot4(CT, (base_c + sl_c) % 4)
                                 : 4'($urandom);
            dout = mask_d[tap_d] ? rot8(DT, (base_d + sl_d) % 8)
                                 : 8'($urandom);
        end
    end

    task automatic clr_counts();
        n_ld_c = 0; n_ld_d = 0; n_bs_c = 0; n_bs_d = 0; n_excl = 0;
    endtask

    task automatic pulse_start();
        @(negedge sysclk); start = 1'b1;
        @(negedge sysclk); start = 1'b0;
    endtask

    task automatic run(input string nm, input logic [31:0] mc,
                       input logic [31:0] md, input int sc, input int sd,
                       input bit poke);
        int cs, cl, ds, dl, n;
        bit c_ok, d_ok;
        mask_c = mc; mask_d = md;
        base_c = (4 - sc) % 4; base_d = (8 - sd) % 8;
        @(negedge sysclk);
        clr_counts();
        pulse_start();
        n = 0;
        while (busy && n < 9000) begin
            @(negedge sysclk);
            n++;
            if (poke && n == 1500) start = 1'b1;
            if (poke && n == 1501) start = 1'b0;
        end
        best_eye(mc, cs, cl);
        best_eye(md, ds, dl);
        c_ok = cl >= 4;
        d_ok = c_ok && dl >= 4;
        check({nm, "_busy"}, busy, 0);
        check({nm, "_locked"}, locked, int'(d_ok));
        check({nm, "_fail"}, fail, int'(!d_ok));
        check({nm, "_ldc"}, n_ld_c, c_ok ? 33 : 32);
        check({nm, "_ldd"}, n_ld_d, c_ok ? (d_ok ? 33 : 32) : 0);
        check({nm, "_bsc"}, n_bs_c, c_ok ? sc : 0);
        check({nm, "_bsd"}, n_bs_d, d_ok ? sd : 0);
        check({nm, "_excl"}, n_excl, 0);
        if (c_ok) check({nm, "_cdly"}, cdly, cs + cl / 2);
        if (d_ok) check({nm, "_ddly"}, ddly, ds + dl / 2);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0;
        mask_c = '0; mask_d = '0; base_c = 0; base_d = 0;
        clr_counts();
        #2 rst_n = 1'b0;
        #1 check("rst_outs", outs(), 0);
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        check("idle_outs", outs(), 0);

        run("clean", win(10, 19), win(3, 20), 0, 0, 1'b0);
        check("clean_cdly_abs", cdly, 15);
        check("clean_ddly_abs", ddly, 12);
        run("slip", win(8, 22), win(3, 20), 3, 0, 1'b0);
        run("narrow", win(10, 19), win(5, 7), 0, 0, 1'b0);
        run("tie", win(2, 6) | win(20, 24), win(0, 31), 1, 5, 1'b0);
        check("tie_cdly_abs", cdly, 4);
        run("ignore", win(10, 19), win(3, 20), 0, 0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            logic [31:0] mc, md;
            int lo;
            lo = $urandom_range(0, 28);
            mc = win(lo, lo + $urandom_range(2, 12));
            if ($urandom_range(0, 1) == 1) begin
                lo = $urandom_range(0, 28);
                mc = mc | win(lo, lo + $urandom_range(0, 8));
            end
            lo = $urandom_range(0, 28);
            md = win(lo, lo + $urandom_range(2, 14));
            run($sformatf("rnd%0d", k), mc, md,
                $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
        end

        mask_c = win(10, 19); mask_d = win(3, 20);
        base_c = 0; base_d = 0;
        @(negedge sysclk);
        clr_counts();
        pulse_start();
        n = 0;
        while (n_ld_c < 18 && n < 3000) begin
            @(negedge sysclk);
            n++;
        end
        check("mid_tap", tap_c, 17);
        repeat (16 + 10) @(negedge sysclk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1 check("mid_rst_outs", outs(), 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        clr_counts();
        repeat (300) @(negedge sysclk);
        check("post_outs", outs(), 0);
        check("post_loads", n_ld_c + n_ld_d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
